router_drain_arbiter: RTL and testbench
=======================================

ROUTER_DRAIN_ARBITER -- requirements
Module: router_drain_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 30, meaning: stalled-cycle limit before a granted FIFO is soft-reset (legal range 2..255).
REQ-002 clockf  input  1  single clock; all state updates on rising edge.
REQ-003 resetf  input  1  asynchronous, active-high reset.
REQ-004 fifo_empty_0/1/2  input  1 each  output-FIFO empty flags; a FIFO requests when its flag is low.
REQ-005 pkt_end_0/1/2  input  1 each  head word of the FIFO is the last (parity) byte of its packet.
REQ-006 out_ready  input  1  downstream link accepts a word this cycle.
REQ-007 read_enb_0/1/2  output  1 each  pop strobe to the corresponding FIFO.
REQ-008 sel  output  2  index of the granted FIFO that drives the shared link mux (0..2).
REQ-009 out_valid  output  1  shared link carries a valid word this cycle.
REQ-010 soft_reset_0/1/2  output  1 each  one-cycle flush pulse to the corresponding FIFO.
REQ-011 busy  output  1  arbiter is holding a grant or flushing.

Function
REQ-012 The block SHALL implement three states: ARB_IDLE, ARB_XFER, ARB_FLUSH.
REQ-013 ARB_IDLE: if any FIFO requests, the block SHALL grant the first requester searching from ptr upward, wrapping 2->0, register sel = winner, and enter ARB_XFER next cycle; with no request it SHALL stay in ARB_IDLE.
REQ-014 In ARB_IDLE, out_valid, all read_enb_x and all soft_reset_x SHALL be 0.
REQ-015 ARB_XFER: out_valid SHALL be high exactly when FIFO[sel] is not empty; read_enb_sel SHALL equal out_valid AND out_ready, combinationally; non-granted read_enb SHALL be 0.
REQ-016 A transfer is a cycle with out_valid AND out_ready; a transfer with pkt_end_sel high SHALL return the FSM to ARB_IDLE next cycle with ptr = (sel+1) mod 3.
REQ-017 The grant SHALL be packet-atomic: no other FIFO is granted until REQ-016 or REQ-019 ends the grant, even if FIFO[sel] goes empty mid-packet.
REQ-018 An 8-bit stall counter SHALL clear on entry to ARB_XFER and on every transfer, and increment on every other ARB_XFER cycle.
REQ-019 When the stall counter equals TIMEOUT-1 and no transfer occurs that cycle, the FSM SHALL enter ARB_FLUSH.
REQ-020 ARB_FLUSH: soft_reset_sel SHALL be high for exactly that one cycle, read_enb_x and out_valid SHALL be 0, and the FSM SHALL return to ARB_IDLE with ptr = (sel+1) mod 3.
REQ-021 A transfer coinciding with the timeout cycle SHALL take precedence: no flush, counter clears.
REQ-022 busy SHALL be high in ARB_XFER and ARB_FLUSH, low in ARB_IDLE.
REQ-023 A single-word packet (pkt_end high on the first transfer) SHALL complete in one ARB_XFER cycle; back-to-back packets SHALL incur exactly one ARB_IDLE cycle between grants.

Reset
REQ-024 On resetf high, asynchronously: state = ARB_IDLE, ptr = 0, sel = 0, stall counter = 0; therefore out_valid, read_enb_x, soft_reset_x, busy SHALL all read 0.
REQ-025 Reset asserted mid-packet SHALL abandon the grant with no soft_reset pulse; after release, arbitration restarts from FIFO 0.

Configuration
REQ-026 Macro ROUTER_ARB_TIMEOUT_EN: when defined, REQ-018..REQ-021 apply; when undefined, the stall counter and ARB_FLUSH are not built, soft_reset_x are tied 0, and a grant is held indefinitely until pkt_end.

Verification
REQ-027 All FIFOs non-empty, 3-word packets, out_ready=1 -> grants in order 0,1,2,0; read_enb pulses 3 cycles each; one idle cycle between grants.
REQ-028 Only FIFO 2 requests after reset -> sel=2 on second cycle, ptr=0 after its packet ends; next FIFO 1 request granted before FIFO 2.
REQ-029 Grant FIFO 1, out_ready held 0 for 40 cycles, TIMEOUT=30 (macro defined) -> soft_reset_1 single pulse on the 31st stalled cycle, then ARB_IDLE; macro undefined -> no pulse, grant held.
REQ-030 Grant FIFO 0, out_ready low 29 cycles, transfer on the 30th -> no soft_reset; counter cleared.
REQ-031 FIFO 0 empties mid-packet while FIFO 1 requests -> out_valid low, sel stays 0, FIFO 1 not granted until FIFO 0 delivers pkt_end.
REQ-032 resetf pulsed mid-packet on FIFO 1 -> all outputs 0 immediately, no soft_reset, next grant to FIFO 0 if requesting.

Source files
------------

// File: rtl/router_drain_arbiter.sv
// router_drain_arbiter: packet-atomic round-robin drain of three output FIFOs onto one link.
// Define ROUTER_ARB_TIMEOUT_EN to build the stall counter and the ARB_FLUSH soft-reset path.
module router_drain_arbiter #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clockf,
  input  logic       resetf,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       pkt_end_0,
  input  logic       pkt_end_1,
  input  logic       pkt_end_2,
  input  logic       out_ready,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       busy
);
  typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_FLUSH} state_t;
  state_t     r_state, w_nxt_state;
  logic [1:0] r_sel, r_ptr, w_nxt_sel, w_nxt_ptr, w_c1, w_c2, w_win, w_sel_inc;
  logic [2:0] w_req, w_end, w_rd;
  logic       w_valid, w_xfer;
`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam logic [7:0] LIM = 8'(TIMEOUT - 1);
  logic [7:0] r_stall, w_nxt_stall;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign w_req = ~{fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_end = {pkt_end_2, pkt_end_1, pkt_end_0};

  always_comb begin
    w_c1        = inc3(r_ptr);
    w_c2        = inc3(w_c1);
    w_win       = w_req[r_ptr] ? r_ptr : w_req[w_c1] ? w_c1 : w_c2;
    w_sel_inc   = inc3(r_sel);
    w_valid     = (r_state == ARB_XFER) && w_req[r_sel];
    w_xfer      = w_valid && out_ready;
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_ptr   = r_ptr;
`ifdef ROUTER_ARB_TIMEOUT_EN
    w_nxt_stall = r_stall;
`endif
    case (r_state)
      ARB_IDLE: if (|w_req) begin
        w_nxt_state = ARB_XFER;
        w_nxt_sel   = w_win;
`ifdef ROUTER_ARB_TIMEOUT_EN
        w_nxt_stall = 8'd0;
`endif
      end
      ARB_XFER: begin
`ifdef ROUTER_ARB_TIMEOUT_EN
        // a transfer on the limit cycle wins over the flush
        w_nxt_stall = w_xfer ? 8'd0 : r_stall + 8'd1;
        if (!w_xfer && r_stall == LIM) w_nxt_state = ARB_FLUSH;
`endif
        if (w_xfer && w_end[r_sel]) begin
          w_nxt_state = ARB_IDLE;
          w_nxt_ptr   = w_sel_inc;
        end
      end
      ARB_FLUSH: begin
        w_nxt_state = ARB_IDLE;
        w_nxt_ptr   = w_sel_inc;
      end
      default: w_nxt_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clockf or posedge resetf) begin
    if (resetf) begin
      r_state <= ARB_IDLE;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
`ifdef ROUTER_ARB_TIMEOUT_EN
      r_stall <= 8'd0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_sel   <= w_nxt_sel;
      r_ptr   <= w_nxt_ptr;
`ifdef ROUTER_ARB_TIMEOUT_EN
      r_stall <= w_nxt_stall;
`endif
    end
  end

  assign w_rd = {3{w_xfer}} & (3'b001 << r_sel);
  assign {read_enb_2, read_enb_1, read_enb_0} = w_rd;
  assign sel       = r_sel;
  assign out_valid = w_valid;
  assign busy      = r_state != ARB_IDLE;
`ifdef ROUTER_ARB_TIMEOUT_EN
  assign {soft_reset_2, soft_reset_1, soft_reset_0} = (r_state == ARB_FLUSH) ? (3'b001 << r_sel) : 3'b000;
`else
  assign {soft_reset_2, soft_reset_1, soft_reset_0} = 3'b000;
`endif
endmodule

// File: tb/tb_router_drain_arbiter.sv
// tb_router_drain_arbiter: directed bench with a FIFO word model and a grant-order scoreboard.
module tb_router_drain_arbiter;
  logic       clk = 1'b0, rst = 1'b1, out_ready = 1'b1;
  logic [2:0] emp = 3'b111, pe = 3'b000, hold = 3'b000;
  logic [2:0] rd, sr;
  logic [1:0] sel;
  logic       out_valid, busy, prev_busy = 1'b0;
  logic       read_enb_0, read_enb_1, read_enb_2, soft_reset_0, soft_reset_1, soft_reset_2;
  int         cnt[3] = '{0, 0, 0};
  int         plen[3] = '{1, 1, 1};
  int         exp_q[$];
  int         n_checks = 0, n_err = 0;
  bit         tmo_en;

  router_drain_arbiter #(.TIMEOUT(30)) dut (
    .clockf(clk), .resetf(rst),
    .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]),
    .pkt_end_0(pe[0]), .pkt_end_1(pe[1]), .pkt_end_2(pe[2]),
    .out_ready(out_ready),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .sel(sel), .out_valid(out_valid),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .busy(busy)
  );

  assign rd = {read_enb_2, read_enb_1, read_enb_0};
  assign sr = {soft_reset_2, soft_reset_1, soft_reset_0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      emp[i] = (cnt[i] == 0) || hold[i];
      pe[i]  = (cnt[i] != 0) && ((cnt[i] - 1) % plen[i] == 0);
    end
  endtask

  task automatic load(input int i, input int n, input int p);
    cnt[i]  = n;
    plen[i] = p;
    drive();
  endtask

  // one clock: apply pops/flushes seen this cycle, then check grant order on a new grant
  task automatic tick();
    logic [2:0] re_s, sr_s;
    #1;
    re_s = rd;
    sr_s = sr;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (re_s[i]) cnt[i]--;
      if (sr_s[i]) cnt[i] = 0;
    end
    drive();
    @(negedge clk);
    #1;
    if (busy && !prev_busy) begin
      if (exp_q.size() == 0) chk("grant_unexpected", {30'd0, sel}, 32'd3);
      else chk("grant_order", {30'd0, sel}, exp_q.pop_front());
    end
    prev_busy = busy;
  endtask

  initial begin
`ifdef ROUTER_ARB_TIMEOUT_EN
    tmo_en = 1'b1;
`else
    tmo_en = 1'b0;
`endif
    @(negedge clk);
    #1;
    chk("reset_outputs", {busy, out_valid, rd, sr, sel}, 0);
    rst = 1'b0;
    tick();
    chk("idle_no_req", {busy, out_valid, rd}, 0);
    // round robin, 3-word packets, FIFO 0 holds two packets
    load(0, 6, 3); load(1, 3, 3); load(2, 3, 3);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
    foreach (exp_q[j]) begin end
    for (int g = 0; g < 4; g++) begin
      int w;
      w = (g == 3) ? 0 : g;
      tick();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rr_g%0d_w%0d", g, k), {busy, sel, rd}, {1'b1, 2'(w), 3'(1 << w)});
        tick();
      end
      chk($sformatf("rr_idle_g%0d", g), {busy, out_valid, rd}, 0);
    end
    // only FIFO 2 requests after reset, then pointer starts at 0
    rst = 1'b1; tick(); rst = 1'b0;
    load(2, 2, 2); exp_q.push_back(2);
    tick(); chk("solo2_sel", {30'd0, sel}, 2);
    tick(); tick(); chk("solo2_done", {busy, rd}, 0);
    load(1, 1, 1); load(2, 1, 1); exp_q.push_back(1); exp_q.push_back(2);
    tick(); chk("ptr_grant1", {out_valid, rd}, {1'b1, 3'b010});
    tick(); chk("single_word_idle", {busy, rd}, 0);
    tick(); chk("ptr_grant2", {out_valid, rd}, {1'b1, 3'b100});
    tick(); chk("ptr_idle", {28'd0, busy, rd}, 0);
    // grant FIFO 1 and stall 40 cycles
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    load(1, 2, 2); exp_q.push_back(1);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (tmo_en) chk($sformatf("stall_c%0d", c), {sr, busy}, (c == 31) ? 4'b0101 : (c < 31) ? 4'b0001 : 4'b0000);
      else chk($sformatf("stall_c%0d", c), {sr, busy}, 4'b0001);
    end
    out_ready = 1'b1;
    tick(); tick();
    chk("stall_end_idle", {busy, sr}, 0);
    // transfer on the limit cycle beats the flush and restarts the count
    out_ready = 1'b0;
    load(0, 2, 2); exp_q.push_back(0);
    for (int c = 1; c <= 29; c++) begin
      tick();
      chk($sformatf("near_c%0d", c), {sr, busy, rd}, {3'b000, 1'b1, 3'b000});
    end
    tick();
    out_ready = 1'b1;
    #1;
    chk("near_xfer30", {sr, rd}, {3'b000, 3'b001});
    tick();
    out_ready = 1'b0;
    for (int c = 31; c <= 59; c++) begin
      #1;
      chk($sformatf("near_c%0d", c), {sr, busy}, 4'b0001);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("near_last", {sr, rd}, {3'b000, 3'b001});
    tick();
    chk("near_done", {busy, sr}, 0);
    // FIFO 0 runs dry mid-packet while FIFO 1 waits
    load(0, 3, 3); exp_q.push_back(0);
    tick(); chk("dry_first", {out_valid, rd}, {1'b1, 3'b001});
    tick();
    hold[0] = 1'b1;
    load(1, 1, 1); exp_q.push_back(1);
    #1;
    chk("dry_start", {busy, out_valid, rd, sel}, {1'b1, 1'b0, 3'b000, 2'd0});
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("dry_hold%0d", c), {busy, out_valid, rd, sel}, {1'b1, 1'b0, 3'b000, 2'd0});
    end
    hold[0] = 1'b0;
    drive();
    #1;
    chk("dry_resume", {out_valid, rd}, {1'b1, 3'b001});
    tick(); tick();
    chk("dry_end_idle", {busy, rd}, 0);
    tick(); chk("dry_then1", {30'd0, sel}, 1);
    tick();
    // reset mid-packet on FIFO 1
    load(1, 3, 3); exp_q.push_back(1);
    tick(); tick();
    chk("mid_pre", {busy, sel}, {1'b1, 2'd1});
    rst = 1'b1;
    load(0, 2, 2);
    #1;
    chk("mid_reset_now", {busy, out_valid, rd, sr, sel}, 0);
    tick();
    chk("mid_reset_held", {busy, out_valid, rd, sr, sel}, 0);
    rst = 1'b0;
    exp_q.push_back(0); exp_q.push_back(1);
    tick(); chk("mid_regrant0", {30'd0, sel}, 0);
    for (int c = 0; c < 8; c++) tick();
    chk("final_idle", {busy, out_valid, sr}, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
